// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding, the supported operand-width range and the counter sizing helper.
// Optional feature macro used by this block: SEQ_MULT_EARLY_EXIT_EN.
package seq_mult_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 16;

   // The iteration counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: multiplicand (mc), multiplier (mp) and accumulator (acc)
// registers with the conditional 2*WIDTH adder and the two shifters.
// With SEQ_MULT_EARLY_EXIT_EN defined, the iteration is also reported as final
// once the remaining multiplier bits are all zero.
module seq_mult_datapath
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               clear_n,
   input  logic               load,
   input  logic               run,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               cnt_last,
   output logic               final_iter,
   output logic [2*WIDTH-1:0] acc_upd
);

   logic [2*WIDTH-1:0] mc_q, mc_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] acc_sum;
   logic [WIDTH-1:0]   mp_q, mp_d;
   logic [WIDTH-1:0]   mp_shift;

   // Next-state for the operand registers: load fresh operands, or perform one
   // partial-product step (add when the current multiplier LSB is set, then shift).
   always_comb begin
      acc_sum  = mp_q[0] ? (acc_q + mc_q) : acc_q;
      mp_shift = mp_q >> 1;
      mc_d     = mc_q;
      mp_d     = mp_q;
      acc_d    = acc_q;
      if (load) begin
         mc_d  = {{WIDTH{1'b0}}, a};
         mp_d  = b;
         acc_d = '0;
      end else if (run) begin
         mc_d  = mc_q << 1;
         mp_d  = mp_shift;
         acc_d = acc_sum;
      end
   end

   // Operand registers; reset clears them so an aborted operation leaves nothing behind.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         mc_q  <= '0;
         mp_q  <= '0;
         acc_q <= '0;
      end else begin
         mc_q  <= mc_d;
         mp_q  <= mp_d;
         acc_q <= acc_d;
      end
   end

   // The accumulator value including this cycle's addition is what gets published.
   assign acc_upd = acc_sum;

`ifdef SEQ_MULT_EARLY_EXIT_EN
   assign final_iter = cnt_last || (mp_shift == '0);
`else
   assign final_iter = cnt_last;
`endif

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier with start/done handshake.
// Holds the IDLE/RUN FSM, the iteration counter and the registered
// busy/done/product outputs; the arithmetic lives in seq_mult_datapath.
// Optional feature macro: SEQ_MULT_EARLY_EXIT_EN (ends RUN once the remaining
// multiplier bits are zero; the default build always runs WIDTH cycles).
module seq_multiplier
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               clear_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = cnt_width(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("seq_multiplier: WIDTH out of supported range");
   end

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic               load;
   logic               run;
   logic               cnt_last;
   logic               final_iter;
   logic [2*WIDTH-1:0] acc_upd;

   assign load     = (state_q == ST_IDLE) && start;
   assign run      = (state_q == ST_RUN);
   assign cnt_last = (cnt_q == CW'(WIDTH - 1));

   seq_mult_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk        (clk),
      .clear_n    (clear_n),
      .load       (load),
      .run        (run),
      .a          (a),
      .b          (b),
      .cnt_last   (cnt_last),
      .final_iter (final_iter),
      .acc_upd    (acc_upd)
   );

   // FSM next-state: start is only honoured in IDLE, and the final RUN step
   // publishes the product, pulses done and drops busy in the same edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      product_d = product_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (final_iter) begin
               state_d   = ST_IDLE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               product_d = acc_upd;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=8.
// Expected products are queued when an operation is launched and compared
// whenever the DUT pulses done; latency and busy length are checked per operation.
module tb_seq_multiplier;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clear_n;
   logic        start4, start8;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  product4;
   logic [15:0] product8;

   int vecCount  = 0;
   int failCount = 0;

   logic [31:0] q4[$];
   logic [31:0] q8[$];
   logic [7:0]  prev4;
   logic [15:0] prev8;

   typedef struct {
      bit          wide;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [31:0] prod;
      string       name;
   } vec_t;

   vec_t vecs[14];

   seq_multiplier #(.WIDTH(4)) dut4 (
      .clk     (clk),
      .clear_n (clear_n),
      .start   (start4),
      .a       (a4),
      .b       (b4),
      .busy    (busy4),
      .done    (done4),
      .product (product4)
   );

   seq_multiplier #(.WIDTH(8)) dut8 (
      .clk     (clk),
      .clear_n (clear_n),
      .start   (start8),
      .a       (a8),
      .b       (b8),
      .busy    (busy8),
      .done    (done8),
      .product (product8)
   );

   // Compare one observed value against its expectation and log mismatches.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // RUN length for multiplier value bv at width w, as the build is configured.
   function automatic int expLat(input logic [7:0] bv, input int w);
      int hi;
      hi = 1;
      for (int i = 0; i < w; i++) if (bv[i]) hi = i + 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
      return hi;
`else
      return (hi > 0) ? w : 0;
`endif
   endfunction

   // Scoreboard side: every done pops an expectation; between dones the product must hold.
   always @(negedge clk) begin
      if (clear_n) begin
         if (done4) begin
            if (q4.size() == 0) checkOutput("unexpected done w4", done4, 0);
            else checkOutput("product w4", product4, q4.pop_front());
         end else begin
            checkOutput("product hold w4", product4, prev4);
         end
         if (done8) begin
            if (q8.size() == 0) checkOutput("unexpected done w8", done8, 0);
            else checkOutput("product w8", product8, q8.pop_front());
         end else begin
            checkOutput("product hold w8", product8, prev8);
         end
      end
      prev4 = product4;
      prev8 = product8;
   end

   // Launch one operation, then scramble the operands and time done/busy.
   task automatic applyStimulus(input bit wide, input logic [7:0] av, input logic [7:0] bv,
                                input logic [31:0] expProd, input string name);
      int cycles;
      int busyCycles;
      int lat;
      lat = expLat(bv, wide ? 8 : 4);
      @(negedge clk);
      if (wide) begin
         start8 = 1'b1; a8 = av; b8 = bv; q8.push_back(expProd);
      end else begin
         start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; q4.push_back(expProd);
      end
      @(negedge clk);
      start4 = 1'b0;
      start8 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      cycles     = 0;
      busyCycles = 0;
      while (!(wide ? done8 : done4) && cycles < 40) begin
         if (wide ? busy8 : busy4) busyCycles++;
         @(negedge clk);
         cycles++;
      end
      checkOutput({name, " latency"}, cycles, lat);
      checkOutput({name, " busy cycles"}, busyCycles, lat);
      checkOutput({name, " busy at done"}, wide ? busy8 : busy4, 0);
   endtask

   initial begin
      int cycles;
      int doneSeen;
      logic [7:0] ra, rb;

      vecs[0]  = '{1'b0, 8'd15,  8'd15,  32'd225,   "w4 15x15"};
      vecs[1]  = '{1'b0, 8'd0,   8'd9,   32'd0,     "w4 0x9"};
      vecs[2]  = '{1'b0, 8'd7,   8'd0,   32'd0,     "w4 7x0"};
      vecs[3]  = '{1'b0, 8'd1,   8'd1,   32'd1,     "w4 1x1"};
      vecs[4]  = '{1'b0, 8'd8,   8'd8,   32'd64,    "w4 8x8"};
      vecs[5]  = '{1'b0, 8'd15,  8'd1,   32'd15,    "w4 15x1"};
      vecs[6]  = '{1'b0, 8'd6,   8'd10,  32'd60,    "w4 6x10"};
      vecs[7]  = '{1'b1, 8'd255, 8'd255, 32'd65025, "w8 255x255"};
      vecs[8]  = '{1'b1, 8'd200, 8'd3,   32'd600,   "w8 200x3"};
      vecs[9]  = '{1'b1, 8'd100, 8'd1,   32'd100,   "w8 100x1"};
      vecs[10] = '{1'b1, 8'd1,   8'd128, 32'd128,   "w8 1x128"};
      vecs[11] = '{1'b1, 8'd0,   8'd0,   32'd0,     "w8 0x0"};
      vecs[12] = '{1'b1, 8'd170, 8'd85,  32'd14450, "w8 170x85"};
      vecs[13] = '{1'b1, 8'd13,  8'd17,  32'd221,   "w8 13x17"};

      start4 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      clear_n = 1'b1;
      #1 clear_n = 1'b0;
      #2;
      checkOutput("reset busy w4", busy4, 0);
      checkOutput("reset done w4", done4, 0);
      checkOutput("reset product w4", product4, 0);
      checkOutput("reset busy w8", busy8, 0);
      checkOutput("reset product w8", product8, 0);
      #9 clear_n = 1'b1;

      for (int i = 0; i < 14; i++)
         applyStimulus(vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].name);

      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i % 2 == 0) begin
            ra[7:4] = 4'h0; rb[7:4] = 4'h0;
            applyStimulus(1'b0, ra, rb, 32'(ra) * 32'(rb), "w4 random");
         end else begin
            applyStimulus(1'b1, ra, rb, 32'(ra) * 32'(rb), "w8 random");
         end
      end

      // start held high: back-to-back results, operands wiggled mid-run are ignored
      @(negedge clk);
      start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
      q4.push_back(32'd15);
      for (int k = 0; k < 3; k++) begin
         cycles = 0;
         do begin
            @(negedge clk);
            cycles++;
            if (cycles == 2) begin a4 = 4'd9; b4 = 4'd9; end
            if (cycles == 4) begin a4 = 4'd3; b4 = 4'd5; end
         end while (!done4 && cycles < 40);
         if (!done4) begin a4 = 4'd3; b4 = 4'd5; end
         checkOutput("held-start interval", cycles, expLat(8'd5, 4) + 1);
         if (k < 2) q4.push_back(32'd15);
         else start4 = 1'b0;
      end

      // reset in the middle of 12x13: everything clears at once, nothing resumes
      @(negedge clk);
      start4 = 1'b1; a4 = 4'd12; b4 = 4'd13;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      checkOutput("busy before abort", busy4, 1);
      @(posedge clk);
      #2 clear_n = 1'b0;
      #1;
      checkOutput("abort busy w4", busy4, 0);
      checkOutput("abort done w4", done4, 0);
      checkOutput("abort product w4", product4, 0);
      checkOutput("abort product w8", product8, 0);
      q4.delete();
      @(negedge clk);
      #2 clear_n = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done4) doneSeen++;
      end
      checkOutput("no done after abort", doneSeen, 0);
      checkOutput("idle after abort", busy4, 0);

      applyStimulus(1'b0, 8'd12, 8'd13, 32'd156, "w4 12x13 after reset");
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
      $finish;
   end

endmodule
